// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction-side OBI arbiter.
package cv32e40p_pkg;

  localparam int INSTR_ARB_NUM_REQ = 2;

  typedef logic instr_arb_id_t;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } instr_arb_lock_e;

  // Round-robin pick between the two requesters; a conflict goes to the one not granted last.
  function automatic instr_arb_id_t instr_arb_rr_pick(
    input logic [INSTR_ARB_NUM_REQ-1:0] req,
    input instr_arb_id_t                last
  );
    instr_arb_id_t pick;
    case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/cv32e40p_instr_arb_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered instruction fetches.
module cv32e40p_instr_arb_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  instr_arb_id_t    i_push_id,
  input  logic             i_pop,
  output instr_arb_id_t    o_head_id,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_full_bypass
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  instr_arb_id_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    o_empty       = (r_count == '0);
    o_full        = (r_count == CNT_W'(DEPTH));
    w_pop         = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept a push.
    o_full_bypass = o_full && !w_pop;
    w_push        = i_push && !o_full_bypass;
    o_head_id     = r_mem[r_rd_ptr];
    o_count       = r_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

endmodule

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-requester arbiter onto one OBI instruction port with in-order response routing.
module cv32e40p_instr_obi_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ID_PRIO         = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INSTR_ARB_NUM_REQ-1:0]        req_i,
  input  logic [INSTR_ARB_NUM_REQ-1:0][31:0]  addr_i,
  output logic [INSTR_ARB_NUM_REQ-1:0]        gnt_o,
  output logic [INSTR_ARB_NUM_REQ-1:0]        rvalid_o,
  output logic [31:0]                         rdata_o,
  output logic [INSTR_ARB_NUM_REQ-1:0]        err_o,
  output logic                                instr_req_o,
  output logic [31:0]                         instr_addr_o,
  input  logic                                instr_gnt_i,
  input  logic                                instr_rvalid_i,
  input  logic [31:0]                         instr_rdata_i,
  input  logic                                instr_err_i,
  output logic                                busy_o
);

  localparam int unsigned   CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam instr_arb_id_t LAST_RST = (ID_PRIO == 0) ? 1'b1 : 1'b0;

  instr_arb_lock_e r_lock_state;
  instr_arb_id_t   r_locked_id;
  instr_arb_id_t   r_last;

  instr_arb_id_t    w_sel;
  instr_arb_id_t    w_head;
  logic             w_any;
  logic             w_locked;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_full_bypass;
  logic [CNT_W-1:0] w_count;

  cv32e40p_instr_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_push        (w_push),
    .i_push_id     (w_sel),
    .i_pop         (instr_rvalid_i),
    .o_head_id     (w_head),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_full_bypass (w_full_bypass)
  );

  always_comb begin
    w_any    = |req_i;
    w_locked = (r_lock_state == ARB_LOCKED);
    w_sel    = w_locked ? r_locked_id : instr_arb_rr_pick(req_i, r_last);

    // Once a request is on the bus it is held until granted, whatever the requester does.
    instr_req_o  = (w_any || w_locked) && !w_full_bypass;
    instr_addr_o = addr_i[w_sel];
    w_push       = instr_req_o && instr_gnt_i;

    gnt_o        = '0;
    gnt_o[w_sel] = w_push;

    rvalid_o         = '0;
    err_o            = '0;
    rvalid_o[w_head] = instr_rvalid_i && !w_empty;
    err_o[w_head]    = instr_rvalid_i && !w_empty && instr_err_i;
    rdata_o          = instr_rdata_i;

    busy_o = !w_empty || w_locked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_state <= ARB_UNLOCKED;
      r_locked_id  <= 1'b0;
      r_last       <= LAST_RST;
    end else begin
      if (instr_req_o && !instr_gnt_i) begin
        r_lock_state <= ARB_LOCKED;
        r_locked_id  <= w_sel;
      end else if (w_push) begin
        r_lock_state <= ARB_UNLOCKED;
      end
      if (w_push) begin
        r_last <= w_sel;
      end
    end
  end

`ifndef SYNTHESIS
  a_lock_hold: assert property (@(posedge clk) disable iff (rst)
    (instr_req_o && !instr_gnt_i) |=> (req_i[r_locked_id] && $stable(instr_addr_o)));

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    instr_rvalid_i |-> !w_empty);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    (w_count <= CNT_W'(MAX_OUTSTANDING)) && (w_full == (w_count == CNT_W'(MAX_OUTSTANDING))));
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// Directed bench for the instruction OBI arbiter with hand-computed expectations.
module tb_cv32e40p_instr_obi_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        req_i;
  logic [1:0][31:0]  addr_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [31:0]       rdata_o;
  logic [1:0]        err_o;
  logic              instr_req_o;
  logic [31:0]       instr_addr_o;
  logic              instr_gnt_i;
  logic              instr_rvalid_i;
  logic [31:0]       instr_rdata_i;
  logic              instr_err_i;
  logic              busy_o;

  int n_checks = 0;
  int n_errors = 0;

  cv32e40p_instr_obi_arbiter #(
    .MAX_OUTSTANDING (2),
    .ID_PRIO         (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .addr_i         (addr_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] req, input logic gnt, input logic rv,
                     input logic [31:0] rd, input logic err);
    req_i          = req;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    instr_err_i    = err;
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] exp_r;

    rst = 1'b1;
    addr_i = '0;
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    bus(2'b00, 1'b1, 1'b0, '0, 1'b0);
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_req", instr_req_o, 1'b0);
    check("rst_rvalid", rvalid_o, 2'b00);
    check("rst_err", err_o, 2'b00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_count", dut.w_count, 0);
    addr_i[0] = 32'h100;
    bus(2'b01, 1'b0, 1'b0, '0, 1'b0);
    check("rst_req_passthru", instr_req_o, 1'b1);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;

    // Single requester: three fetches, response one cycle after grant
    addr_i[0] = 32'h100;
    bus(2'b01, 1'b1, 1'b0, '0, 1'b0);
    check("s_req", instr_req_o, 1'b1);
    check("s_addr0", instr_addr_o, 32'h100);
    check("s_gnt0", gnt_o, 2'b01);
    tick();
    addr_i[0] = 32'h104;
    bus(2'b01, 1'b1, 1'b1, 32'hD000_0100, 1'b0);
    check("s_addr1", instr_addr_o, 32'h104);
    check("s_rv0", rvalid_o, 2'b01);
    check("s_rd0", rdata_o, 32'hD000_0100);
    tick();
    addr_i[0] = 32'h108;
    bus(2'b01, 1'b1, 1'b1, 32'hD000_0104, 1'b0);
    check("s_gnt2", gnt_o, 2'b01);
    check("s_rv1", rvalid_o, 2'b01);
    tick();
    bus(2'b00, 1'b0, 1'b1, 32'hD000_0108, 1'b0);
    check("s_rv2", rvalid_o, 2'b01);
    check("s_rd2", rdata_o, 32'hD000_0108);
    check("s_busy_last", busy_o, 1'b1);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("s_idle_rv", rvalid_o, 2'b00);
    check("s_idle_busy", busy_o, 1'b0);

    // Contention from reset: port 0 first, then alternate; responses follow grant order
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr_i[0] = 32'h1000;
    addr_i[1] = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      bus((i < 5) ? 2'b11 : 2'b00, (i < 5), (i > 0), 32'hA0 + i, 1'b0);
      exp_g = (i >= 5) ? 2'b00 : ((i % 2) ? 2'b10 : 2'b01);
      exp_r = (i == 0) ? 2'b00 : (((i - 1) % 2) ? 2'b10 : 2'b01);
      check($sformatf("c_gnt%0d", i), gnt_o, exp_g);
      check($sformatf("c_rv%0d", i), rvalid_o, exp_r);
      if (i < 5) begin
        check($sformatf("c_addr%0d", i), instr_addr_o, (i % 2) ? 32'h2000 : 32'h1000);
      end
      tick();
    end
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("c_busy_end", busy_o, 1'b0);

    // Lock: port 0 stalls three cycles; port 1 (which would win round-robin) waits
    addr_i[0] = 32'h200;
    addr_i[1] = 32'h300;
    bus(2'b01, 1'b0, 1'b0, '0, 1'b0);
    check("l_addr0", instr_addr_o, 32'h200);
    check("l_gnt0", gnt_o, 2'b00);
    tick();
    bus(2'b11, 1'b0, 1'b0, '0, 1'b0);
    check("l_addr1", instr_addr_o, 32'h200);
    check("l_busy1", busy_o, 1'b1);
    check("l_req1", instr_req_o, 1'b1);
    tick();
    bus(2'b11, 1'b0, 1'b0, '0, 1'b0);
    check("l_addr2", instr_addr_o, 32'h200);
    tick();
    bus(2'b11, 1'b1, 1'b0, '0, 1'b0);
    check("l_addr3", instr_addr_o, 32'h200);
    check("l_gnt3", gnt_o, 2'b01);
    tick();
    bus(2'b10, 1'b1, 1'b1, 32'hB0, 1'b0);
    check("l_gnt4", gnt_o, 2'b10);
    check("l_addr4", instr_addr_o, 32'h300);
    check("l_rv4", rvalid_o, 2'b01);
    tick();
    bus(2'b00, 1'b0, 1'b1, 32'hB1, 1'b0);
    check("l_rv5", rvalid_o, 2'b10);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("l_busy_end", busy_o, 1'b0);

    // Full: two grants, responses held off; request reappears with the first response
    addr_i[0] = 32'h400;
    bus(2'b01, 1'b1, 1'b0, '0, 1'b0);
    check("f_gnt0", gnt_o, 2'b01);
    tick();
    addr_i[0] = 32'h404;
    bus(2'b01, 1'b1, 1'b0, '0, 1'b0);
    check("f_gnt1", gnt_o, 2'b01);
    tick();
    addr_i[0] = 32'h408;
    for (int i = 0; i < 3; i++) begin
      bus(2'b01, 1'b1, 1'b0, '0, 1'b0);
      check($sformatf("f_req_blk%0d", i), instr_req_o, 1'b0);
      check($sformatf("f_gnt_blk%0d", i), gnt_o, 2'b00);
      check($sformatf("f_cnt%0d", i), dut.w_count, 2);
      tick();
    end
    bus(2'b01, 1'b1, 1'b1, 32'hC0, 1'b0);
    check("f_req_bypass", instr_req_o, 1'b1);
    check("f_gnt_bypass", gnt_o, 2'b01);
    check("f_rv0", rvalid_o, 2'b01);
    tick();
    bus(2'b00, 1'b0, 1'b1, 32'hC1, 1'b0);
    check("f_rv1", rvalid_o, 2'b01);
    check("f_cnt_after", dut.w_count, 2);
    tick();
    bus(2'b00, 1'b0, 1'b1, 32'hC2, 1'b0);
    check("f_rv2", rvalid_o, 2'b01);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("f_busy_end", busy_o, 1'b0);

    // Error on the second response, which belongs to port 1
    addr_i[0] = 32'h500;
    addr_i[1] = 32'h600;
    bus(2'b01, 1'b1, 1'b0, '0, 1'b0);
    check("e_gnt0", gnt_o, 2'b01);
    tick();
    bus(2'b10, 1'b1, 1'b1, 32'hE0, 1'b0);
    check("e_gnt1", gnt_o, 2'b10);
    check("e_rv0", rvalid_o, 2'b01);
    check("e_err0", err_o, 2'b00);
    tick();
    bus(2'b00, 1'b0, 1'b1, 32'hE1, 1'b1);
    check("e_rv1", rvalid_o, 2'b10);
    check("e_err1", err_o, 2'b10);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b1);
    check("e_err_unqual", err_o, 2'b00);
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);

    // Reset with two outstanding, last grant to port 0
    addr_i[0] = 32'h700;
    addr_i[1] = 32'h704;
    bus(2'b10, 1'b1, 1'b0, '0, 1'b0);
    check("r_gnt0", gnt_o, 2'b10);
    tick();
    bus(2'b01, 1'b1, 1'b0, '0, 1'b0);
    check("r_gnt1", gnt_o, 2'b01);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("r_cnt_pre", dut.w_count, 2);
    check("r_busy_pre", busy_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("r_cnt_post", dut.w_count, 0);
    check("r_busy_post", busy_o, 1'b0);
    bus(2'b11, 1'b0, 1'b0, '0, 1'b0);
    check("r_conflict_addr", instr_addr_o, 32'h700);
    tick();
    bus(2'b11, 1'b1, 1'b0, '0, 1'b0);
    check("r_conflict_gnt", gnt_o, 2'b01);
    tick();
    // Lock port 1, then reset: lock and round-robin pointer must both clear
    bus(2'b10, 1'b0, 1'b1, 32'hF0, 1'b0);
    check("r_rv_drain", rvalid_o, 2'b01);
    check("r_lock_addr", instr_addr_o, 32'h704);
    tick();
    check("r_locked_busy", busy_o, 1'b1);
    rst = 1'b1;
    bus(2'b10, 1'b0, 1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;
    bus(2'b11, 1'b1, 1'b0, '0, 1'b0);
    check("r_lock_clr_busy", busy_o, 1'b0);
    check("r_lock_clr_gnt", gnt_o, 2'b01);
    check("r_lock_clr_addr", instr_addr_o, 32'h700);
    tick();
    bus(2'b00, 1'b0, 1'b1, 32'hF1, 1'b0);
    check("r_final_rv", rvalid_o, 2'b01);
    tick();
    bus(2'b00, 1'b0, 1'b0, '0, 1'b0);
    check("r_final_busy", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
